sram_arbiter_ctrl: RTL

- Sequences the asynchronous 16-bit external SRAM for the LC-3 top level and shares it between two requesters.
  - Port A: CPU memory cycle (MAR/MDR path).
  - Port B: debug/loader path (switch-driven memory poke and peek during Run/Continue halts).
- Drives CE, UB, LB, OE, WE, ADDR and the bidirectional Data bus.
- Arbitrates round-robin and presents a registered read word plus a one-cycle done pulse per requester.

---
 rtl/sram_arbiter_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_ctrl
// Purpose  : Round-robin two-port sequencer for an asynchronous 16-bit SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_be,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_be,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
        $error("sram_arbiter_ctrl: WAIT_CYCLES must be >= 1");
    end

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_access  = 2'd1;
    localparam logic [1:0] c_recover = 2'd2;

    localparam int                 c_cnt_w    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_last_b;
    logic               r_sel_b;
    logic               r_we;
    logic [1:0]         r_be;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_a_gnt, r_b_gnt, r_a_done, r_b_done;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_ce, r_ub, r_lb, r_oe, r_wen, r_drive;

    logic               w_grant, w_grant_b, w_last_access;
    logic               w_op_we;
    logic [1:0]         w_op_be;
    logic [ADDR_W-1:0]  w_op_addr;
    logic [DATA_W-1:0]  w_op_wdata;

    always_comb begin
        w_next        = r_state;
        w_grant       = 1'b0;
        w_grant_b     = 1'b0;
        w_last_access = (r_state == c_access) && (r_cnt == '0);
        unique case (r_state)
            c_idle: begin
                if (a_req || b_req) begin
                    w_grant   = 1'b1;
                    // On a tie the port that was not served last wins.
                    w_grant_b = b_req && (!a_req || !r_last_b);
                    w_next    = c_access;
                end
            end
            c_access:  if (r_cnt == '0) w_next = c_recover;
            c_recover: w_next = c_idle;
            default:   w_next = c_idle;
        endcase

        w_op_we    = r_we;
        w_op_be    = r_be;
        w_op_addr  = r_addr;
        w_op_wdata = r_wdata;
        if (w_grant) begin
            w_op_we    = w_grant_b ? b_we    : a_we;
            w_op_be    = w_grant_b ? b_be    : a_be;
            w_op_addr  = w_grant_b ? b_addr  : a_addr;
            w_op_wdata = w_grant_b ? b_wdata : a_wdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= c_idle;
        else        r_state <= w_next;
    end

    // Pin registers are loaded from the next state so the SRAM sees clean, glitch-free controls.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt    <= '0;
            r_last_b <= 1'b1;
            r_sel_b  <= 1'b0;
            r_we     <= 1'b0;
            r_be     <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_a_gnt  <= 1'b0;
            r_b_gnt  <= 1'b0;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_rdata  <= '0;
            r_ce     <= 1'b1;
            r_ub     <= 1'b1;
            r_lb     <= 1'b1;
            r_oe     <= 1'b1;
            r_wen    <= 1'b1;
            r_drive  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_cnt    <= c_cnt_load;
                r_sel_b  <= w_grant_b;
                r_last_b <= w_grant_b;
                r_we     <= w_op_we;
                r_be     <= w_op_be;
                r_addr   <= w_op_addr;
                r_wdata  <= w_op_wdata;
            end else if ((r_state == c_access) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
            r_a_gnt  <= w_grant && !w_grant_b;
            r_b_gnt  <= w_grant && w_grant_b;
            r_a_done <= w_last_access && !r_sel_b;
            r_b_done <= w_last_access && r_sel_b;
            if (w_last_access && !r_we) r_rdata <= Data;
            r_ce    <= (w_next == c_idle);
            r_ub    <= !((w_next != c_idle) && w_op_be[1]);
            r_lb    <= !((w_next != c_idle) && w_op_be[0]);
            r_oe    <= !((w_next == c_access) && !w_op_we);
            r_wen   <= !((w_next == c_access) && w_op_we);
            r_drive <= (w_next != c_idle) && w_op_we;
        end
    end

    assign Data   = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign a_gnt  = r_a_gnt;
    assign b_gnt  = r_b_gnt;
    assign a_done = r_a_done;
    assign b_done = r_b_done;
    assign rdata  = r_rdata;
    assign busy   = (r_state != c_idle);
    assign CE     = r_ce;
    assign UB     = r_ub;
    assign LB     = r_lb;
    assign OE     = r_oe;
    assign WE     = r_wen;
    assign ADDR   = r_addr;

endmodule
`default_nettype wire
